// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - issue-side and ALU-side handshake bundle for alu_issue_stage
interface alu_issue_stage_if #(
    parameter int DataWidth = 32,
    parameter int RegAddrW  = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [6:0]           in_opcode;
    logic [2:0]           in_funct3;
    logic                 in_funct7b5;
    logic [RegAddrW-1:0]  in_rs1;
    logic [RegAddrW-1:0]  in_rs2;
    logic [RegAddrW-1:0]  in_rd;
    logic [DataWidth-1:0] in_rs1_data;
    logic [DataWidth-1:0] in_rs2_data;
    logic [DataWidth-1:0] in_imm;
    logic [DataWidth-1:0] in_pc;

    logic                 ex_valid;
    logic                 ex_ready;
    logic [3:0]           ex_func;
    logic [DataWidth-1:0] ex_op1;
    logic [DataWidth-1:0] ex_op2;
    logic [RegAddrW-1:0]  ex_rd;
    logic                 ex_we;
    logic                 ex_is_load;
    logic                 ex_illegal;

    modport master (
        output in_valid, in_opcode, in_funct3, in_funct7b5, in_rs1, in_rs2, in_rd,
               in_rs1_data, in_rs2_data, in_imm, in_pc, ex_ready,
        input  in_ready, ex_valid, ex_func, ex_op1, ex_op2, ex_rd, ex_we,
               ex_is_load, ex_illegal
    );

    modport slave (
        input  in_valid, in_opcode, in_funct3, in_funct7b5, in_rs1, in_rs2, in_rd,
               in_rs1_data, in_rs2_data, in_imm, in_pc, ex_ready,
        output in_ready, ex_valid, ex_func, ex_op1, ex_op2, ex_rd, ex_we,
               ex_is_load, ex_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I ID/EX issue stage with decode, bypass and load-use stall; ISSUE_STALL_CNT_EN enables stall_cnt
module alu_issue_stage #(
    parameter int DataWidth = 32,
    parameter int RegAddrW  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    alu_issue_stage_if.slave     bus,
    input  logic [DataWidth-1:0] alu_result,
    input  logic                 mem_we,
    input  logic [RegAddrW-1:0]  mem_rd,
    input  logic [DataWidth-1:0] mem_data,
    input  logic                 mem_data_ok,
    input  logic                 wb_we,
    input  logic [RegAddrW-1:0]  wb_rd,
    input  logic [DataWidth-1:0] wb_data,
    output logic [31:0]          stall_cnt
);
    localparam logic [3:0] FN_ZERO = 4'd0;
    localparam logic [3:0] FN_ADD  = 4'd1;
    localparam logic [3:0] FN_SUB  = 4'd2;
    localparam logic [3:0] FN_SLL  = 4'd3;
    localparam logic [3:0] FN_SLT  = 4'd4;
    localparam logic [3:0] FN_XOR  = 4'd5;
    localparam logic [3:0] FN_OR   = 4'd6;
    localparam logic [3:0] FN_AND  = 4'd7;
    localparam logic [3:0] FN_SRL  = 4'd8;
    localparam logic [3:0] FN_SRA  = 4'd9;
    localparam logic [3:0] FN_SLTU = 4'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {OP1_ZERO, OP1_RS1, OP1_PC} op1_sel_e;
    typedef enum logic [1:0] {OP2_ZERO, OP2_RS2, OP2_IMM, OP2_FOUR} op2_sel_e;

    logic                 ex_valid_q;
    logic [3:0]           ex_func_q;
    logic [DataWidth-1:0] ex_op1_q;
    logic [DataWidth-1:0] ex_op2_q;
    logic [RegAddrW-1:0]  ex_rd_q;
    logic                 ex_we_q;
    logic                 ex_load_q;
    logic                 ex_ill_q;

    logic [3:0]           dec_func;
    logic                 dec_we;
    logic                 dec_load;
    logic                 dec_ill;
    logic                 use_rs1;
    logic                 use_rs2;
    op1_sel_e             op1_sel;
    op2_sel_e             op2_sel;

    logic [DataWidth-1:0] rs1_val;
    logic [DataWidth-1:0] rs2_val;
    logic [DataWidth-1:0] op1_nxt;
    logic [DataWidth-1:0] op2_nxt;
    logic                 hazard;
    logic                 in_ready;
    logic                 accept;

    function automatic logic [3:0] arith_func(input logic [2:0] f3, input logic alt);
        logic [3:0] f;
        f = FN_ZERO;
        case (f3)
            3'b000: f = alt ? FN_SUB : FN_ADD;
            3'b001: f = FN_SLL;
            3'b010: f = FN_SLT;
            3'b011: f = FN_SLTU;
            3'b100: f = FN_XOR;
            3'b101: f = alt ? FN_SRA : FN_SRL;
            3'b110: f = FN_OR;
            default: f = FN_AND;
        endcase
        return f;
    endfunction

    always_comb begin
        dec_func = FN_ZERO;
        dec_we   = 1'b0;
        dec_load = 1'b0;
        dec_ill  = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        op1_sel  = OP1_ZERO;
        op2_sel  = OP2_ZERO;
        case (bus.in_opcode)
            OPC_OP: begin
                dec_func = arith_func(bus.in_funct3, bus.in_funct7b5);
                {use_rs1, use_rs2} = 2'b11;
                op1_sel  = OP1_RS1;
                op2_sel  = OP2_RS2;
                dec_we   = 1'b1;
            end
            OPC_OPIMM: begin
                // There is no SUBI: bit 30 only selects SRA among the immediate forms.
                dec_func = arith_func(bus.in_funct3,
                                      bus.in_funct7b5 && (bus.in_funct3 == 3'b101));
                use_rs1  = 1'b1;
                op1_sel  = OP1_RS1;
                op2_sel  = OP2_IMM;
                dec_we   = 1'b1;
            end
            OPC_LOAD, OPC_STORE: begin
                dec_func = FN_ADD;
                use_rs1  = 1'b1;
                op1_sel  = OP1_RS1;
                op2_sel  = OP2_IMM;
                dec_load = (bus.in_opcode == OPC_LOAD);
                dec_we   = (bus.in_opcode == OPC_LOAD);
            end
            OPC_LUI: begin
                dec_func = FN_ADD;
                op2_sel  = OP2_IMM;
                dec_we   = 1'b1;
            end
            OPC_AUIPC: begin
                dec_func = FN_ADD;
                op1_sel  = OP1_PC;
                op2_sel  = OP2_IMM;
                dec_we   = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec_func = FN_ADD;
                op1_sel  = OP1_PC;
                op2_sel  = OP2_FOUR;
                dec_we   = 1'b1;
            end
            OPC_BRANCH: begin
                if (bus.in_funct3[2:1] == 2'b01) begin
                    dec_ill = 1'b1;
                end else begin
                    case (bus.in_funct3[2:1])
                        2'b00:   dec_func = FN_SUB;
                        2'b10:   dec_func = FN_SLT;
                        default: dec_func = FN_SLTU;
                    endcase
                    {use_rs1, use_rs2} = 2'b11;
                    op1_sel = OP1_RS1;
                    op2_sel = OP2_RS2;
                end
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Youngest producer wins; a held load has no result yet so it never forwards.
    function automatic logic [DataWidth-1:0] bypass(input logic [RegAddrW-1:0] idx,
                                                    input logic [DataWidth-1:0] rf);
        logic [DataWidth-1:0] v;
        if (idx == '0)
            v = '0;
        else if (ex_valid_q && ex_we_q && !ex_load_q && (ex_rd_q == idx))
            v = alu_result;
        else if (mem_we && mem_data_ok && (mem_rd == idx))
            v = mem_data;
        else if (wb_we && (wb_rd == idx))
            v = wb_data;
        else
            v = rf;
        return v;
    endfunction

    function automatic logic load_dep(input logic [RegAddrW-1:0] idx);
        return (idx != '0) &&
               ((ex_valid_q && ex_load_q && (ex_rd_q == idx)) ||
                (mem_we && !mem_data_ok && (mem_rd == idx)));
    endfunction

    always_comb begin
        rs1_val = bypass(bus.in_rs1, bus.in_rs1_data);
        rs2_val = bypass(bus.in_rs2, bus.in_rs2_data);
        hazard  = (use_rs1 && load_dep(bus.in_rs1)) || (use_rs2 && load_dep(bus.in_rs2));
    end

    always_comb begin
        op1_nxt = '0;
        case (op1_sel)
            OP1_RS1: op1_nxt = rs1_val;
            OP1_PC:  op1_nxt = bus.in_pc;
            default: op1_nxt = '0;
        endcase
        op2_nxt = '0;
        case (op2_sel)
            OP2_RS2:  op2_nxt = rs2_val;
            OP2_IMM:  op2_nxt = bus.in_imm;
            OP2_FOUR: op2_nxt = DataWidth'(4);
            default:  op2_nxt = '0;
        endcase
    end

    assign in_ready = (!ex_valid_q || bus.ex_ready) && !hazard && !flush;
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_func_q  <= FN_ZERO;
            ex_op1_q   <= '0;
            ex_op2_q   <= '0;
            ex_rd_q    <= '0;
            ex_we_q    <= 1'b0;
            ex_load_q  <= 1'b0;
            ex_ill_q   <= 1'b0;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
        end else if (accept) begin
            ex_valid_q <= 1'b1;
            ex_func_q  <= dec_func;
            ex_op1_q   <= op1_nxt;
            ex_op2_q   <= op2_nxt;
            ex_rd_q    <= bus.in_rd;
            ex_we_q    <= dec_we && (bus.in_rd != '0);
            ex_load_q  <= dec_load;
            ex_ill_q   <= dec_ill;
        end else if (bus.ex_ready) begin
            ex_valid_q <= 1'b0;
        end
    end

`ifdef ISSUE_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_q <= '0;
        else if (bus.in_valid && hazard && !flush && (stall_q != 32'hFFFF_FFFF))
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

    assign bus.in_ready   = in_ready;
    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_func    = ex_func_q;
    assign bus.ex_op1     = ex_op1_q;
    assign bus.ex_op2     = ex_op2_q;
    assign bus.ex_rd      = ex_rd_q;
    assign bus.ex_we      = ex_we_q;
    assign bus.ex_is_load = ex_load_q;
    assign bus.ex_illegal = ex_ill_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage with directed RV32I vectors
module tb_alu_issue_stage;
    localparam int DW = 32;
    localparam int AW = 5;
`ifdef ISSUE_STALL_CNT_EN
    localparam int EXP_STALL = 1;
`else
    localparam int EXP_STALL = 0;
`endif

    localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011, LUI = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, BR = 7'b1100011;

    typedef struct {
        logic [3:0]  func;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        we;
        logic        ld;
        logic        ill;
        bit          chk_ops;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] alu_result = '0;
    logic          mem_we = 1'b0;
    logic [AW-1:0] mem_rd = '0;
    logic [DW-1:0] mem_data = '0;
    logic          mem_data_ok = 1'b0;
    logic          wb_we = 1'b0;
    logic [AW-1:0] wb_rd = '0;
    logic [DW-1:0] wb_data = '0;
    logic [31:0]   stall_cnt;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_issue_stage_if #(.DataWidth(DW), .RegAddrW(AW)) bus ();

    alu_issue_stage #(.DataWidth(DW), .RegAddrW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus),
        .alu_result(alu_result),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data), .mem_data_ok(mem_data_ok),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_cnt(stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input logic we, input logic ld,
                                input logic ill, input bit ops);
        exp_t e;
        e.func = f; e.op1 = a; e.op2 = b; e.rd = rd;
        e.we = we; e.ld = ld; e.ill = ill; e.chk_ops = ops;
        return e;
    endfunction

    task automatic present(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] imm, input logic [31:0] pc);
        bus.in_opcode = opc; bus.in_funct3 = f3; bus.in_funct7b5 = f7;
        bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd;
        bus.in_rs1_data = d1; bus.in_rs2_data = d2; bus.in_imm = imm; bus.in_pc = pc;
        bus.in_valid = 1'b1;
    endtask

    // Presents, waits (bounded) for in_ready, then lets the capturing edge pass.
    task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [31:0] pc,
                        input bit push, input exp_t e);
        int n;
        present(opc, f3, f7, rs1, rs2, rd, d1, d2, imm, pc);
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: in_ready stayed 0 for opcode %b", opc);
        end else if (push) begin
            q.push_back(e);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.ex_valid && bus.ex_ready) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_out: func %h op1 %h with empty scoreboard",
                             bus.ex_func, bus.ex_op1);
                end else begin
                    e = q.pop_front();
                    chk("sb_func", 32'(bus.ex_func), 32'(e.func));
                    if (e.chk_ops) begin
                        chk("sb_op1", bus.ex_op1, e.op1);
                        chk("sb_op2", bus.ex_op2, e.op2);
                    end
                    chk("sb_rd_we_ld_ill",
                        32'({bus.ex_rd, bus.ex_we, bus.ex_is_load, bus.ex_illegal}),
                        32'({e.rd, e.we, e.ld, e.ill}));
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.ex_valid), 0);
        chk({tag, "_func"}, 32'(bus.ex_func), 0);
        chk({tag, "_op1"}, bus.ex_op1, 0);
        chk({tag, "_op2"}, bus.ex_op2, 0);
        chk({tag, "_flags"}, 32'({bus.ex_rd, bus.ex_we, bus.ex_is_load, bus.ex_illegal}), 0);
        chk({tag, "_stall"}, stall_cnt, 0);
    endtask

    initial begin : stim
        bus.in_valid = 1'b0; bus.ex_ready = 1'b1;
        bus.in_opcode = '0; bus.in_funct3 = '0; bus.in_funct7b5 = 1'b0;
        bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0;
        bus.in_rs1_data = '0; bus.in_rs2_data = '0; bus.in_imm = '0; bus.in_pc = '0;
        #1;
        chk_all_zero("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        send(OP, 3'b000, 0, 1, 2, 3, 5, 7, 0, 0, 1, mk(1, 5, 7, 3, 1, 0, 0, 1));
        send(OPI, 3'b101, 1, 1, 0, 4, 32'h8000_0000, 0, 3, 0, 1,
             mk(9, 32'h8000_0000, 3, 4, 1, 0, 0, 1));
        send(OPI, 3'b000, 1, 2, 0, 9, 10, 0, 32'h400, 0, 1, mk(1, 10, 32'h400, 9, 1, 0, 0, 1));

        alu_result = 9; wb_we = 1; wb_rd = 5; wb_data = 1;
        send(OP, 3'b000, 0, 1, 2, 5, 4, 5, 0, 0, 1, mk(1, 4, 5, 5, 1, 0, 0, 1));
        send(OP, 3'b000, 0, 5, 5, 6, 32'hdead, 32'hdead, 0, 0, 1, mk(1, 9, 9, 6, 1, 0, 0, 1));
        wb_rd = 11; wb_data = 77;
        idle(1);
        send(OP, 3'b000, 0, 11, 0, 10, 3, 55, 0, 0, 1, mk(1, 77, 0, 10, 1, 0, 0, 1));
        wb_we = 0; alu_result = 0;

        send(LUI, 3'b000, 0, 1, 2, 12, 99, 99, 32'h1234_5000, 32'h100, 1,
             mk(1, 0, 32'h1234_5000, 12, 1, 0, 0, 1));
        send(AUIPC, 3'b000, 0, 1, 2, 13, 99, 99, 32'h1000, 32'h200, 1,
             mk(1, 32'h200, 32'h1000, 13, 1, 0, 0, 1));
        send(JAL, 3'b000, 0, 1, 2, 14, 99, 99, 32'h40, 32'h300, 1, mk(1, 32'h300, 4, 14, 1, 0, 0, 1));
        send(JALR, 3'b000, 0, 3, 0, 15, 99, 99, 32'h8, 32'h400, 1, mk(1, 32'h400, 4, 15, 1, 0, 0, 1));
        send(BR, 3'b000, 0, 1, 2, 0, 3, 4, 32'h10, 0, 1, mk(2, 3, 4, 0, 0, 0, 0, 1));
        send(BR, 3'b110, 0, 1, 2, 0, 3, 4, 32'h10, 0, 1, mk(10, 3, 4, 0, 0, 0, 0, 1));
        send(BR, 3'b010, 0, 1, 2, 0, 3, 4, 32'h10, 0, 1, mk(0, 0, 0, 0, 0, 0, 1, 0));
        send(7'b1111111, 3'b000, 0, 1, 2, 3, 3, 4, 0, 0, 1, mk(0, 0, 0, 3, 0, 0, 1, 0));
        send(OPI, 3'b000, 0, 1, 0, 0, 6, 0, 5, 0, 1, mk(1, 6, 5, 0, 0, 0, 0, 1));
        send(ST, 3'b010, 0, 2, 3, 5, 32'h100, 32'h77, 32'h10, 0, 1,
             mk(1, 32'h100, 32'h10, 5, 0, 0, 0, 1));
        idle(1);

        // Load-use: one bubble, then the load data arrives through MEM.
        send(LD, 3'b010, 0, 1, 0, 7, 32'h1000, 0, 8, 0, 1, mk(1, 32'h1000, 8, 7, 1, 1, 0, 1));
        present(OP, 3'b000, 0, 7, 0, 8, 32'hbad, 0, 0, 0);
        @(negedge clk);
        chk("lu_in_ready_stall", 32'(bus.in_ready), 0);
        @(posedge clk); #1;
        mem_we = 1; mem_rd = 7; mem_data_ok = 1; mem_data = 42;
        @(negedge clk);
        chk("lu_bubble_valid", 32'(bus.ex_valid), 0);
        chk("lu_in_ready_go", 32'(bus.in_ready), 1);
        chk("lu_stall_cnt", stall_cnt, EXP_STALL);
        q.push_back(mk(1, 42, 0, 8, 1, 0, 0, 1));
        @(posedge clk); #1;
        bus.in_valid = 0; mem_we = 0; mem_data_ok = 0;
        idle(1);

        // MEM-stage load still pending stalls until mem_data_ok rises.
        mem_we = 1; mem_rd = 20; mem_data_ok = 0; mem_data = 5;
        present(OP, 3'b000, 0, 20, 0, 21, 32'hbad, 0, 0, 0);
        @(negedge clk);
        chk("mem_pend_stall", 32'(bus.in_ready), 0);
        @(posedge clk); #1;
        mem_data_ok = 1;
        @(negedge clk);
        chk("mem_ok_ready", 32'(bus.in_ready), 1);
        q.push_back(mk(1, 5, 0, 21, 1, 0, 0, 1));
        @(posedge clk); #1;
        bus.in_valid = 0; mem_we = 0; mem_data_ok = 0;
        idle(2);

        // Backpressure then flush: held XOR is dropped, incoming OR never captured.
        bus.ex_ready = 0;
        send(OP, 3'b100, 0, 1, 2, 15, 32'hF0, 32'h0F, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
        present(OP, 3'b110, 0, 1, 2, 16, 1, 2, 0, 0);
        @(negedge clk);
        chk("bp_in_ready", 32'(bus.in_ready), 0);
        chk("bp_valid", 32'(bus.ex_valid), 1);
        chk("bp_func", 32'(bus.ex_func), 5);
        chk("bp_op1", bus.ex_op1, 32'hF0);
        @(posedge clk); #1;
        flush = 1;
        @(negedge clk);
        chk("fl_in_ready", 32'(bus.in_ready), 0);
        chk("bp_op2", bus.ex_op2, 32'h0F);
        @(posedge clk); #1;
        flush = 0; bus.in_valid = 0;
        @(negedge clk);
        chk("fl_valid", 32'(bus.ex_valid), 0);
        @(posedge clk); #1;
        bus.ex_ready = 1;

        // Async reset while an instruction is held.
        bus.ex_ready = 0;
        send(OP, 3'b001, 0, 1, 2, 17, 1, 2, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 0;
        #1;
        chk_all_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1; bus.ex_ready = 1;
        send(OP, 3'b010, 0, 1, 2, 18, 32'hFFFF_FFFF, 1, 0, 0, 1,
             mk(4, 32'hFFFF_FFFF, 1, 18, 1, 0, 0, 1));
        idle(3);
        chk("sb_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
